riscv_mem_responder: RTL and testbench

Single-port memory responder that sits on the far end of a core memory port (imem or dmem) in the test harness. It accepts packed memory request messages over a val/rdy handshake, performs word or sub-word reads and writes on an internal byte-addressed array, and returns packed response messages after a fixed, parameterised latency. It has no response back-pressure, which matches the core's response ports (val only, no rdy). Two instances serve the two instruction ports and one serves the data port.

---
 rtl/riscv_mem_responder.sv | 122 ++++++++++++
 tb/tb_riscv_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_responder.sv
// Memory responder for a core memory port: accepts packed requests over val/rdy, performs
// word/sub-word accesses on a byte-addressed array, and returns responses after LATENCY cycles.
module riscv_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] memreq_msg,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  output logic [34:0] memresp_msg,
  output logic        memresp_val,
  input  logic        stall,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(MEM_WORDS);

  logic          req_type;
  logic [31:0]   req_addr;
  logic [1:0]    req_len;
  logic [31:0]   req_data;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;
  logic [1:0]    req_off;
  logic          unused_addr_bits;

  assign {req_type, req_addr, req_len, req_data} = memreq_msg;
  assign req_idx  = req_addr[AW+1:2];
  assign req_off  = req_addr[1:0];
  assign load_idx = load_addr[AW+1:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], load_addr[31:AW+2], load_addr[1:0]};

  logic        accept;
  logic        wr_en;
  logic [3:0]  len_mask;
  logic [3:0]  lane_en;
  logic [31:0] len_mask32;
  logic [31:0] lane_mask32;
  logic [31:0] mem_rd;
  logic [31:0] rdata;
  logic [31:0] wr_base;
  logic [31:0] wr_word;

  logic [31:0] mem_q [MEM_WORDS];

  // Requests presented while reset is asserted are never accepted.
  assign memreq_rdy = !stall;
  assign accept     = memreq_val && memreq_rdy && reset;
  assign wr_en      = accept && req_type;
  assign mem_rd     = mem_q[req_idx];

  always_comb begin
    len_mask = 4'b1111;
    case (req_len)
      2'd1:    len_mask = 4'b0001;
      2'd2:    len_mask = 4'b0011;
      2'd3:    len_mask = 4'b0111;
      default: len_mask = 4'b1111;
    endcase
    // Lanes shifted past byte 3 fall off the top: no wrap into the next word.
    lane_en     = len_mask << req_off;
    len_mask32  = '0;
    lane_mask32 = '0;
    for (int k = 0; k < 4; k++) begin
      len_mask32[8*k +: 8]  = {8{len_mask[k]}};
      lane_mask32[8*k +: 8] = {8{lane_en[k]}};
    end
    rdata   = (mem_rd >> {req_off, 3'b000}) & len_mask32;
    // A loader write to the same word lands first; request lanes override it.
    wr_base = (load_en && (load_idx == req_idx)) ? load_data : mem_rd;
    wr_word = (wr_base & ~lane_mask32) | ((req_data << {req_off, 3'b000}) & lane_mask32);
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
    if (wr_en) begin
      mem_q[req_idx] <= wr_word;
    end
  end

  logic [LATENCY-1:0] val_q;
  logic [LATENCY-1:0] val_d;
  logic [34:0]        msg_q [LATENCY];
  logic [34:0]        msg_d [LATENCY];

  always_comb begin
    val_d = '0;
    for (int i = 0; i < LATENCY; i++) begin
      msg_d[i] = '0;
    end
    val_d[0] = accept;
    msg_d[0] = accept ? {req_type, req_len, (req_type ? 32'h0 : rdata)} : 35'h0;
    for (int i = 1; i < LATENCY; i++) begin
      val_d[i] = val_q[i-1];
      msg_d[i] = msg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        msg_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      for (int i = 0; i < LATENCY; i++) begin
        msg_q[i] <= msg_d[i];
      end
    end
  end

  assign memresp_val = val_q[LATENCY-1];
  assign memresp_msg = msg_q[LATENCY-1];

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Bench for riscv_mem_responder: LATENCY=1 and LATENCY=3 instances share stimulus and are
// checked against a byte-array reference model with per-instance response queues.
module tb_riscv_mem_responder;

  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [66:0] req_msg = '0;
  logic        req_val = 1'b0;
  logic        stall = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        rdy1, val1, rdy3, val3;
  logic [34:0] msg1, msg3;

  always #5 clk = ~clk;

  riscv_mem_responder #(.MEM_WORDS(MW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_n), .memreq_msg(req_msg), .memreq_val(req_val), .memreq_rdy(rdy1),
    .memresp_msg(msg1), .memresp_val(val1), .stall(stall), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data));

  riscv_mem_responder #(.MEM_WORDS(MW), .LATENCY(3)) dut3 (
    .clk(clk), .reset(rst_n), .memreq_msg(req_msg), .memreq_val(req_val), .memreq_rdy(rdy3),
    .memresp_msg(msg3), .memresp_val(val3), .stall(stall), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data));

  typedef struct {
    int          due;
    logic [34:0] msg;
  } resp_t;

  typedef struct {
    logic        t;
    logic [31:0] a;
    logic [1:0]  l;
    logic [31:0] d;
    logic [31:0] exp_data;
  } vec_t;

  logic [7:0] mem_b [MW*4];
  resp_t q1[$];
  resp_t q3[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [34:0] act, logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: applies one clock edge's effects from the inputs currently driven.
  function automatic void model_edge();
    logic        t = req_msg[66];
    logic [31:0] a = req_msg[65:34];
    logic [1:0]  l = req_msg[33:32];
    logic [31:0] d = req_msg[31:0];
    logic        acc = rst_n && req_val && !stall;
    logic [31:0] rd = '0;
    int base = ((a >> 2) % MW) * 4;
    int off = int'(a[1:0]);
    int nb = (l == 2'd0) ? 4 : int'(l);
    int lb = ((load_addr >> 2) % MW) * 4;
    logic [34:0] m;
    if (acc) begin
      for (int i = 0; i < nb; i++)
        if (off + i < 4) rd[8*i +: 8] = mem_b[base + off + i];
    end
    if (load_en) begin
      for (int b = 0; b < 4; b++) mem_b[lb + b] = load_data[8*b +: 8];
    end
    if (acc && t) begin
      for (int i = 0; i < nb; i++)
        if (off + i < 4) mem_b[base + off + i] = d[8*i +: 8];
    end
    if (acc) begin
      m = {t, l, (t ? 32'h0 : rd)};
      q1.push_back('{cyc + 1, m});
      q3.push_back('{cyc + 3, m});
    end
  endfunction

  function automatic void check_outs();
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("val1", val1, 1);
      chk("msg1", msg1, q1[0].msg);
      void'(q1.pop_front());
    end else chk("val1_idle", val1, 0);
    if (q3.size() > 0 && q3[0].due == cyc) begin
      chk("val3", val3, 1);
      chk("msg3", msg3, q3[0].msg);
      void'(q3.pop_front());
    end else chk("val3_idle", val3, 0);
  endfunction

  task automatic drive(input logic v, input logic t, input logic [31:0] a, input logic [1:0] l,
                       input logic [31:0] d, input logic st, input logic le,
                       input logic [31:0] la, input logic [31:0] ld);
    req_val = v; req_msg = {t, a, l, d}; stall = st;
    load_en = le; load_addr = la; load_data = ld;
    #1;
    chk("rdy1", rdy1, !st);
    chk("rdy3", rdy3, !st);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outs();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] ld);
    drive(0, 0, 0, 0, 0, 0, 1, la, ld);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{0, 32'h100, 2'd0, 32'h0,    32'hDEADBEEF},
      '{0, 32'h102, 2'd1, 32'h0,    32'h000000AD},
      '{0, 32'h101, 2'd2, 32'h0,    32'h0000ADBE},
      '{1, 32'h103, 2'd1, 32'h12,   32'h0},
      '{0, 32'h100, 2'd0, 32'h0,    32'h12ADBEEF},
      '{1, 32'h103, 2'd2, 32'h3456, 32'h0},
      '{0, 32'h100, 2'd0, 32'h0,    32'h56ADBEEF},
      '{0, 32'h100 + MW*4, 2'd0, 32'h0, 32'h56ADBEEF},
      '{0, 32'h103, 2'd0, 32'h0,    32'h00000056},
      '{0, 32'h102, 2'd3, 32'h0,    32'h000056AD}
    };

    #2 rst_n = 1'b0;
    idle();
    chk("rst_msg1", msg1, 0);
    chk("rst_msg3", msg3, 0);
    idle();
    rst_n = 1'b1;
    idle();

    // Directed table on the LATENCY=1 instance: response visible right after acceptance.
    load(32'h100, 32'hDEADBEEF);
    foreach (vecs[i]) begin
      drive(1, vecs[i].t, vecs[i].a, vecs[i].l, vecs[i].d, 0, 0, 0, 0);
      chk("tbl_val", val1, 1);
      chk("tbl_msg", msg1, {vecs[i].t, vecs[i].l, vecs[i].exp_data});
    end

    // Loader and request in the same cycle on the same word.
    load(32'h200, 32'h11223344);
    drive(1, 0, 32'h200, 2'd0, 0, 0, 1, 32'h200, 32'h55667788);
    chk("ld_rd_pre", msg1, {1'b0, 2'd0, 32'h11223344});
    drive(1, 1, 32'h200, 2'd1, 32'hAA, 0, 1, 32'h200, 32'h99AABBCC);
    drive(1, 0, 32'h200, 2'd0, 0, 0, 0, 0, 0);
    chk("ld_wr_merge", msg1, {1'b0, 2'd0, 32'h99AABBAA});

    // Back-to-back reads on preloaded words 0..7.
    for (int i = 0; i < 8; i++) load(32'(i * 4), 32'(i) * 32'h11111111);
    for (int i = 0; i < 8; i++) drive(1, 0, 32'(i * 4), 2'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle();

    // Stall with valid held high, then resume.
    drive(1, 0, 32'h4, 2'd0, 0, 1, 0, 0, 0);
    drive(1, 0, 32'h4, 2'd0, 0, 1, 0, 0, 0);
    drive(1, 0, 32'h8, 2'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'hC, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle();

    // Reset mid-flight.
    drive(1, 0, 32'h4, 2'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h8, 2'd0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h14, 2'd0, 32'hA5A5A5A5, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_val1", val1, 0);
    chk("midrst_val3", val3, 0);
    chk("midrst_msg3", msg3, 0);
    q1.delete();
    q3.delete();
    drive(1, 0, 32'h4, 2'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    drive(1, 0, 32'h14, 2'd0, 0, 0, 0, 0, 0);
    chk("persist_w5", msg1, {1'b0, 2'd0, 32'hA5A5A5A5});
    for (int i = 0; i < 3; i++) idle();

    // Randomized traffic over words 0..15 with random upper address bits.
    for (int i = 8; i < 16; i++) load(32'(i * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, la;
      a  = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      la = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)),
            $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, la, $urandom);
    end
    for (int i = 0; i < 5; i++) idle();
    chk("drain_q1", 35'(q1.size()), 0);
    chk("drain_q3", 35'(q3.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
